// File: rtl/triangle_wave_checker_pkg.sv
// triangle_wave_checker_pkg: shared state enum, error codes and triangle geometry helpers
package triangle_wave_checker_pkg;
  typedef enum logic [1:0] {EMPTY, ACQ, RISE, FALL} state_t;
  localparam logic [1:0] ERR_STEP = 2'b01;
  localparam logic [1:0] ERR_SHAPE = 2'b10;
  function automatic int max_val(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int ideal_period(input int w);
    return 2 * max_val(w);
  endfunction
endpackage

// File: rtl/triangle_wave_checker_if.sv
// triangle_wave_checker_if: sample stream in, slope/period/error/lock status out
interface triangle_wave_checker_if #(
  parameter int WIDTH = 5,
  parameter int PERIOD_W = 8,
  parameter int ERRCNT_W = 8
);
  logic sample_valid;
  logic [WIDTH-1:0] sample;
  logic dir_up;
  logic peak_pulse;
  logic trough_pulse;
  logic [PERIOD_W-1:0] period;
  logic period_valid;
  logic err_pulse;
  logic [1:0] err_code;
  logic [ERRCNT_W-1:0] err_count;
  logic locked;
  modport master (
    output sample_valid, sample,
    input dir_up, peak_pulse, trough_pulse, period, period_valid,
    input err_pulse, err_code, err_count, locked
  );
  modport slave (
    input sample_valid, sample,
    output dir_up, peak_pulse, trough_pulse, period, period_valid,
    output err_pulse, err_code, err_count, locked
  );
endinterface

// File: rtl/tri_period_meter.sv
// tri_period_meter: trough-to-trough sample counter, period register and clean-period lock
module tri_period_meter
  import triangle_wave_checker_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int PERIOD_W = 8,
  parameter int LOCK_PERIODS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept_i,
  input  logic trough_i,
  input  logic err_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic period_valid_o,
  output logic locked_o
);
  localparam logic [PERIOD_W-1:0] IDEAL = PERIOD_W'(ideal_period(WIDTH));
  localparam int CW = $clog2(LOCK_PERIODS + 1);
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_PERIODS);
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic pv_q, pv_d, have_q, have_d, locked_q, locked_d;
  logic [CW-1:0] clean_q, clean_d;
  // the counter still holds the previous trough's count when the new trough arrives
  always_comb begin
    pv_d = accept_i & trough_i & have_q;
    cnt_d = !accept_i ? cnt_q : trough_i ? PERIOD_W'(1) : &cnt_q ? cnt_q : cnt_q + PERIOD_W'(1);
    period_d = pv_d ? cnt_q : period_q;
    have_d = err_i ? 1'b0 : (accept_i & trough_i) | have_q;
    clean_d = err_i ? '0 : !pv_d ? clean_q : cnt_q != IDEAL ? '0 : clean_q == LOCK_N ? clean_q : clean_q + CW'(1);
    locked_d = clean_d == LOCK_N;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      period_q <= '0;
      pv_q <= 1'b0;
      have_q <= 1'b0;
      clean_q <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      period_q <= period_d;
      pv_q <= pv_d;
      have_q <= have_d;
      clean_q <= clean_d;
      locked_q <= locked_d;
    end
  end
  assign period_o = period_q;
  assign period_valid_o = pv_q;
  assign locked_o = locked_q;
endmodule

// File: rtl/triangle_wave_checker.sv
// triangle_wave_checker: slope tracking, peak/trough detection and step/shape error checking
module triangle_wave_checker
  import triangle_wave_checker_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int PERIOD_W = 8,
  parameter int LOCK_PERIODS = 2,
  parameter int ERRCNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  triangle_wave_checker_if.slave tw
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));
  state_t state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic dir_q, dir_d, peak_q, peak_d, trough_q, trough_d, err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;
  logic up, dn, step_err, shape_err;
  // wrap between MAX and 0 is a step error, so the end points exclude the modular +/-1
  assign up = tw.sample == prev_q + WIDTH'(1) && prev_q != MAX;
  assign dn = tw.sample == prev_q - WIDTH'(1) && prev_q != '0;
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    peak_d = 1'b0;
    trough_d = 1'b0;
    code_d = code_q;
    cnt_d = cnt_q;
    step_err = 1'b0;
    shape_err = 1'b0;
    if (tw.sample_valid) begin
      case (state_q)
        EMPTY: state_d = ACQ;
        ACQ: begin
          if (up) begin
            state_d = RISE;
            dir_d = 1'b1;
          end else if (dn) begin
            state_d = FALL;
            dir_d = 1'b0;
          end else step_err = 1'b1;
        end
        RISE: begin
          if (dn && prev_q == MAX) begin
            state_d = FALL;
            dir_d = 1'b0;
            peak_d = 1'b1;
          end else if (dn) shape_err = 1'b1;
          else if (!up) step_err = 1'b1;
        end
        FALL: begin
          if (up && prev_q == '0) begin
            state_d = RISE;
            dir_d = 1'b1;
            trough_d = 1'b1;
          end else if (up) shape_err = 1'b1;
          else if (!dn) step_err = 1'b1;
        end
      endcase
    end
    err_d = step_err | shape_err;
    if (err_d) begin
      state_d = ACQ;
      dir_d = 1'b0;
      code_d = step_err ? ERR_STEP : ERR_SHAPE;
      cnt_d = &cnt_q ? cnt_q : cnt_q + ERRCNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prev_q <= '0;
      dir_q <= 1'b0;
      peak_q <= 1'b0;
      trough_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= tw.sample_valid ? tw.sample : prev_q;
      dir_q <= dir_d;
      peak_q <= peak_d;
      trough_q <= trough_d;
      err_q <= err_d;
      code_q <= code_d;
      cnt_q <= cnt_d;
    end
  end
  tri_period_meter #(
    .WIDTH(WIDTH),
    .PERIOD_W(PERIOD_W),
    .LOCK_PERIODS(LOCK_PERIODS)
  ) u_meter (
    .clk(clk),
    .rst_n(rst_n),
    .accept_i(tw.sample_valid),
    .trough_i(trough_d),
    .err_i(err_d),
    .period_o(tw.period),
    .period_valid_o(tw.period_valid),
    .locked_o(tw.locked)
  );
  assign tw.dir_up = dir_q;
  assign tw.peak_pulse = peak_q;
  assign tw.trough_pulse = trough_q;
  assign tw.err_pulse = err_q;
  assign tw.err_code = code_q;
  assign tw.err_count = cnt_q;
endmodule
